// File: rtl/cpu_mc.sv
// cpu_mc: parametrised multi-cycle core. Each instruction runs through the states
// FETCH -> EXEC (-> MEM for loads/stores). Instruction and data memory busywait
// handshakes stall the current state.
// Optional feature: define PERF_CNT_EN to add the CYCLE_CNT/INSTR_CNT counter ports.
module cpu_mc #(
  parameter int          DATA_W   = 8,
  parameter int          REG_N    = 8,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [31:0]       PC,
  input  logic [31:0]       INSTRUCTION,
  input  logic              iBUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [DATA_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] WRITEDATA,
  input  logic [DATA_W-1:0] READDATA,
  input  logic              dBUSYWAIT
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       CYCLE_CNT,
  output logic [31:0]       INSTR_CNT
`endif
);
  localparam int RA_W = (REG_N > 1) ? $clog2(REG_N) : 1;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_LWD   = 8'd8;
  localparam logic [7:0] OP_LWI   = 8'd9;
  localparam logic [7:0] OP_SWD   = 8'd10;
  localparam logic [7:0] OP_SWI   = 8'd11;
  localparam logic [7:0] OP_BNE   = 8'd12;
  localparam logic [7:0] OP_SLL   = 8'd13;
  localparam logic [7:0] OP_SRL   = 8'd14;
  localparam logic [7:0] OP_SRA   = 8'd15;
  localparam logic [7:0] OP_ROR   = 8'd16;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rf_q [REG_N];
  logic [DATA_W-1:0] rf_d [REG_N];

  logic [7:0]          opcode;
  logic [RA_W-1:0]     rd, rs1, rs2;
  logic [DATA_W-1:0]   imm_ext, op_a, op_b, alu_res, rf_wdata;
  logic [31:0]         pc_plus4, br_target, shamt;
  logic [5:0]          rot_amt;
  logic [2*DATA_W-1:0] rot_wide;
  logic                rf_we;
  logic                unused_ir;

  assign opcode    = ir_q[31:24];
  assign rd        = ir_q[16 +: RA_W];
  assign rs1       = ir_q[8 +: RA_W];
  assign rs2       = ir_q[0 +: RA_W];
  assign imm_ext   = DATA_W'($signed(ir_q[7:0]));
  assign op_a      = rf_q[rs1];
  assign op_b      = rf_q[rs2];
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{22{ir_q[7]}}, ir_q[7:0], 2'b00};
  assign shamt     = {27'd0, ir_q[4:0]};
  assign rot_amt   = 6'(shamt % 32'(DATA_W));
  assign unused_ir = ^ir_q;

  assign PC        = pc_q;
  assign MEM_READ  = mem_read_q;
  assign MEM_WRITE = mem_write_q;
  assign ADDRESS   = addr_q;
  assign WRITEDATA = wdata_q;

  // ALU and shifter result for the instruction held in IR
  always_comb begin
    alu_res  = '0;
    rot_wide = {op_a, op_a} >> rot_amt;
    case (opcode)
      OP_LOADI: alu_res = imm_ext;
      OP_MOV:   alu_res = op_b;
      OP_ADD:   alu_res = op_a + op_b;
      OP_SUB:   alu_res = op_a - op_b;
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_SLL:   alu_res = (shamt >= 32'(DATA_W)) ? '0 : (op_a << shamt);
      OP_SRL:   alu_res = (shamt >= 32'(DATA_W)) ? '0 : (op_a >> shamt);
      OP_SRA:   alu_res = (shamt >= 32'(DATA_W)) ? {DATA_W{op_a[DATA_W-1]}}
                                                 : DATA_W'($signed(op_a) >>> shamt);
      OP_ROR:   alu_res = rot_wide[DATA_W-1:0];
      default:  alu_res = '0;
    endcase
  end

  // Next-state, PC, memory request and register-write decisions for the FSM
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rf_we       = 1'b0;
    rf_wdata    = alu_res;
    case (state_q)
      ST_FETCH: begin
        if (!iBUSYWAIT) begin
          ir_d    = INSTRUCTION;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_plus4;
        case (opcode)
          OP_LOADI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_SLL, OP_SRL, OP_SRA, OP_ROR: rf_we = 1'b1;
          OP_J:   pc_d = br_target;
          OP_BEQ: if (op_a == op_b) pc_d = br_target;
          OP_BNE: if (op_a != op_b) pc_d = br_target;
          OP_LWD, OP_LWI, OP_SWD, OP_SWI: begin
            state_d     = ST_MEM;
            pc_d        = pc_q;
            addr_d      = (opcode == OP_LWD || opcode == OP_SWD) ? op_b : imm_ext;
            mem_read_d  = (opcode == OP_LWD || opcode == OP_LWI);
            mem_write_d = (opcode == OP_SWD || opcode == OP_SWI);
            if (opcode == OP_SWD || opcode == OP_SWI) wdata_d = op_a;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (!dBUSYWAIT) begin
          rf_we       = mem_read_q;
          rf_wdata    = READDATA;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          pc_d        = pc_plus4;
          state_d     = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Register-file write port
  always_comb begin
    rf_d = rf_q;
    if (rf_we) rf_d[rd] = rf_wdata;
  end

  // All architectural state; reset aborts any access in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rf_q        <= rf_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;

  // An instruction completes whenever EXEC or MEM hands back to FETCH
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    instr_cnt_d = instr_cnt_q;
    if (state_q != ST_FETCH && state_d == ST_FETCH) instr_cnt_d = instr_cnt_q + 32'd1;
  end

  // Free-running cycle and retired-instruction counters
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign CYCLE_CNT = cycle_cnt_q;
  assign INSTR_CNT = instr_cnt_q;
`endif

endmodule
